// File: rtl/router_pkg.sv
// Shared router constants, VC index helpers and the output-VC allocation entry.
// Global VC index = port * NUM_VC + vc.
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int NUM_VC    = 2;
    localparam int NUM_GVC   = NUM_PORTS * NUM_VC;
    localparam int VC_IDX_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    typedef struct packed {
        logic               alloc_vld;
        logic [NUM_GVC-1:0] ovc;
    } alloc_entry_t;

    function automatic int gvc(input int port, input int vc);
        return port * NUM_VC + vc;
    endfunction

    // All global output-VC bits that belong to output port j.
    function automatic logic [NUM_GVC-1:0] port_mask(input int j);
        logic [NUM_GVC-1:0] m;
        m = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            m[j*NUM_VC+v] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/sa_grant_2_vc_grant_if.sv
// Switch-allocation bundle between the VC/switch allocators and the
// grant-to-VC resolver: allocation table updates in, VC/crossbar grants out.
interface sa_grant_2_vc_grant_if;
    import router_pkg::*;

    logic [NUM_GVC-1:0]                vc_alloc_valid;
    logic [NUM_GVC-1:0][NUM_GVC-1:0]   vc_alloc_ovc;
    logic [NUM_GVC-1:0]                vc_tail_sent;
    logic [NUM_GVC-1:0]                vc_ready;
    logic [NUM_GVC-1:0]                credit_avail;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] port_grant;
    logic [NUM_GVC-1:0]                vc_grant;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] xbar_sel;
    logic [NUM_GVC-1:0]                ovc_used;
    logic                              sa_err;

    modport master (
        output vc_alloc_valid, vc_alloc_ovc, vc_tail_sent,
        output vc_ready, credit_avail, port_grant,
        input  vc_grant, xbar_sel, ovc_used, sa_err
    );

    modport slave (
        input  vc_alloc_valid, vc_alloc_ovc, vc_tail_sent,
        input  vc_ready, credit_avail, port_grant,
        output vc_grant, xbar_sel, ovc_used, sa_err
    );

endinterface

// File: rtl/sa_grant_2_vc_grant_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// The pointer moves only when i_upd is high and some request won.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_upd,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_found
);

    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_found;

    always_comb begin
        w_gnt   = '0;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_idx   = IW'((int'(r_ptr) + k) % NUM_REQ);
                w_gnt[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= IW'(NUM_REQ - 1);
        end else if (i_upd && w_found) begin
            r_ptr <= w_idx;
        end
    end

    assign o_gnt   = w_gnt;
    assign o_found = w_found;

endmodule

// File: rtl/sa_grant_2_vc_grant.sv
// Resolves per-port switch grants back to one input VC per port using the
// output-VC allocation table; emits registered VC grants, xbar selects, credit strobes.
module sa_grant_2_vc_grant
    import router_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    sa_grant_2_vc_grant_if.slave bus
);

    alloc_entry_t r_tab [NUM_GVC];

    logic [NUM_GVC-1:0]                  r_vc_grant;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] r_xbar;
    logic [NUM_GVC-1:0]                  r_used;
    logic                                r_err;

    logic [NUM_PORTS-1:0]                w_row_any;
    logic [NUM_PORTS-1:0][NUM_GVC-1:0]   w_mask;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]    w_req;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]    w_gnt;
    logic [NUM_PORTS-1:0]                w_found;

    logic [NUM_GVC-1:0]                  w_vc_grant;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_xbar;
    logic [NUM_GVC-1:0]                  w_used;
    logic                                w_err;

    // A same-cycle realloc beats the tail release so the new packet keeps its VC.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_GVC; v++) begin
            if (reset) begin
                r_tab[v] <= '0;
            end else if (bus.vc_alloc_valid[v]) begin
                r_tab[v].alloc_vld <= 1'b1;
                r_tab[v].ovc       <= bus.vc_alloc_ovc[v];
            end else if (bus.vc_tail_sent[v]) begin
                r_tab[v].alloc_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        w_row_any = '0;
        w_mask    = '0;
        w_req     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_row_any[i] = |bus.port_grant[i];
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (bus.port_grant[i][j]) begin
                    w_mask[i] = w_mask[i] | port_mask(j);
                end
            end
            for (int v = 0; v < NUM_VC; v++) begin
                w_req[i][v] = w_row_any[i]
                            && r_tab[gvc(i, v)].alloc_vld
                            && bus.vc_ready[gvc(i, v)]
                            && (|(r_tab[gvc(i, v)].ovc & bus.credit_avail & w_mask[i]));
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_arb
        rr_arbiter #(
            .NUM_REQ (NUM_VC),
            .IW      (VC_IDX_W)
        ) u_arb (
            .clk     (clk),
            .reset   (reset),
            .i_req   (w_req[gi]),
            .i_upd   (w_row_any[gi]),
            .o_gnt   (w_gnt[gi]),
            .o_found (w_found[gi])
        );
    end

    always_comb begin
        w_vc_grant = '0;
        w_xbar     = '0;
        w_used     = '0;
        w_err      = r_err;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_row_any[i]) begin
                if (w_found[i]) begin
                    for (int j = 0; j < NUM_PORTS; j++) begin
                        w_xbar[j][i] = bus.port_grant[i][j];
                    end
                    for (int v = 0; v < NUM_VC; v++) begin
                        if (w_gnt[i][v]) begin
                            w_vc_grant[gvc(i, v)] = 1'b1;
                            w_used = w_used | r_tab[gvc(i, v)].ovc;
                        end
                    end
                end else begin
                    w_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vc_grant <= '0;
            r_xbar     <= '0;
            r_used     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_vc_grant <= w_vc_grant;
            r_xbar     <= w_xbar;
            r_used     <= w_used;
            r_err      <= w_err;
        end
    end

    assign bus.vc_grant = r_vc_grant;
    assign bus.xbar_sel = r_xbar;
    assign bus.ovc_used = r_used;
    assign bus.sa_err   = r_err;

endmodule

// File: doc/sa_grant_2_vc_grant.md
Name: sa_grant_2_vc_grant

Overview:
Reverse-direction companion to the VC-to-port request conversion in the router's switch-allocation stage. It holds the per-input-VC output-VC allocation table. It takes per-input-port switch grants (input port -> output port) and resolves each one back to the single winning input VC with a per-port round-robin. It emits registered VC grants, crossbar selects and output-VC consumption strobes for credit bookkeeping.

Parameters:
NUM_PORTS, 5, number of router ports (input count equals output count)
NUM_VC, 2, virtual channels per port; global VC index = port*NUM_VC + vc

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
vc_alloc_valid  in  NUM_PORTS*NUM_VC  pulse: VC allocator granted an output VC to input VC i
vc_alloc_ovc  in  [NUM_PORTS*NUM_VC][NUM_PORTS*NUM_VC]  one-hot output VC for input VC i; sampled when vc_alloc_valid[i]
vc_tail_sent  in  NUM_PORTS*NUM_VC  pulse: tail flit of input VC i left; release its allocation
vc_ready  in  NUM_PORTS*NUM_VC  input VC i has a flit at its buffer head
credit_avail  in  NUM_PORTS*NUM_VC  output VC k has at least one downstream credit
port_grant  in  [NUM_PORTS][NUM_PORTS]  switch allocator: input port i granted output port j; at most one bit per row
vc_grant  out  NUM_PORTS*NUM_VC  registered; input VC i dequeues one flit; at most one bit per port group
xbar_sel  out  [NUM_PORTS][NUM_PORTS]  registered; xbar_sel[j][i] = output j takes input i
ovc_used  out  NUM_PORTS*NUM_VC  registered; output VC k consumed one credit this cycle
sa_err  out  1  sticky; a port_grant arrived with no eligible VC

Behaviour:
- Reset has a 1-cycle effect. All outputs clear to 0. Allocation table valid bits clear to 0. Round-robin pointers go to NUM_VC-1, so VC0 has highest priority first. Reset mid-packet drops all allocations.
- Allocation table, one entry per input VC: alloc_vld plus a one-hot ovc.
  - vc_alloc_valid[i] sets alloc_vld and loads ovc at the next edge.
  - vc_tail_sent[i] clears alloc_vld.
  - If both assert in the same cycle, the set wins: the new packet is allocated.
  - vc_alloc_valid on an already-valid entry overwrites it (allocator contract violation; no error raised).
- Eligibility, combinational from current table state. Input VC v of port i is eligible for output port j when all of these hold:
  - alloc_vld[v] is set;
  - ovc[v] lies in the bit range [j*NUM_VC, (j+1)*NUM_VC-1];
  - vc_ready[v] is set;
  - credit_avail of that ovc is set.
- Resolution when port_grant[i][j] = 1:
  - Round-robin over the NUM_VC eligible VCs of port i.
  - Search starts at rr[i]+1 and wraps modulo NUM_VC.
  - The winner w is registered:
    - vc_grant[i*NUM_VC+w] = 1;
    - xbar_sel[j][i] = 1;
    - ovc_used at the winner's ovc index = 1.
  - rr[i] is set to w at the same edge.
- When no port_grant bit is set for port i, rr[i] holds and no outputs are produced for port i.
- When port_grant[i][j] = 1 but no VC is eligible, no outputs are produced for port i and sa_err sets. sa_err clears only on reset.
- Latency: port_grant in cycle N produces outputs in cycle N+1. All outputs are single-cycle pulses, re-evaluated every cycle, so back-to-back grants give back-to-back outputs.
- Table updates and grants in the same cycle: eligibility uses the pre-update table. A VC allocated in cycle N becomes eligible from cycle N+1.
- Port_grant rows with more than one bit set are illegal. Behaviour for them is undefined; the assertion bench flags them.

Decomposition:
- router_pkg holds NUM_PORTS, NUM_VC, VC_IDX_W = $clog2(NUM_VC), the global-VC index helper function, and a typedef for the allocation entry struct (alloc_vld, ovc).
- Sub-module rr_arbiter (NUM_REQ = NUM_VC) is instantiated per input port. It has request, grant and update-enable ports, and owns its pointer register with synchronous active-high reset.

Test Plan:
1. Allocation and grant. Setup: reset; alloc input VC 2 (port1, vc0) to ovc 6 (port3, vc0); vc_ready[2] = 1; credit_avail[6] = 1. Stimulus: port_grant[1][3] = 1 next cycle. Expected one cycle later: vc_grant = 1<<2, xbar_sel[3][1] = 1, ovc_used = 1<<6, sa_err = 0.
2. Round-robin. Setup: VCs 2 and 3 both eligible for output port 3. Stimulus: port_grant[1][3] held 4 cycles. Expected: vc_grant alternates 1<<2, 1<<3, 1<<2, 1<<3.
3. Credit gating. Setup: as scenario 2, but credit_avail[6] = 0. Stimulus: port_grant[1][3] held. Expected: only VC3 wins every cycle, and ovc_used = 1<<7 each cycle.
4. Tail release versus simultaneous realloc.
   - vc_tail_sent[2] alone, then port_grant[1][3]: no output; sa_err = 1.
   - Repeat after reset with vc_tail_sent[2] and vc_alloc_valid[2] (ovc 8) in the same cycle: the entry stays valid with ovc 8, and a grant on output port 4 wins.
5. Parallel ports. Stimulus: port_grant[0][2] and port_grant[4][1] in the same cycle, each with one eligible VC. Expected: both xbar_sel bits, both vc_grant bits and both ovc_used bits set in the same response cycle.
6. Reset mid-stream. Stimulus: assert reset during a continuous grant stream. Expected: all outputs 0 the next cycle; the table is empty, so post-reset grants produce sa_err = 1 until reallocation.
